// File: rtl/iter_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_multiplier_if
// Description : Request/response val/rdy message bundle for iter_multiplier.
//               master = requester side, slave = multiplier side.
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_multiplier_if #(
    parameter int WIDTH = 32
);
    logic                 req_val;
    logic                 req_rdy;
    logic [WIDTH-1:0]     req_msg_a;
    logic [WIDTH-1:0]     req_msg_b;
    logic                 req_signed;
    logic                 resp_val;
    logic                 resp_rdy;
    logic [2*WIDTH-1:0]   resp_msg;

    modport master (
        output req_val, req_msg_a, req_msg_b, req_signed, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg_a, req_msg_b, req_signed, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );
endinterface
`default_nettype wire

// File: rtl/iter_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : iter_multiplier
// Description : Multi-cycle shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//               BITS_PER_CYCLE multiplier bits retired per cycle, optional
//               signed mode (sign-magnitude internally) and early exit.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SIGNED_EN      = 1,
    parameter int EARLY_EXIT     = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    iter_multiplier_if.slave  bus
);

    localparam int c_ITER  = WIDTH / BITS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_neg;
    logic                 r_resp_val;
    logic [2*WIDTH-1:0]   r_resp_msg;

    logic                 w_use_signed;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]     w_b_next;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_result;

    // Operand magnitudes; |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is
    // exactly right when the value is treated as unsigned.
    always_comb begin
        w_use_signed = (SIGNED_EN != 0) && bus.req_signed;
        w_a_mag = (w_use_signed && bus.req_msg_a[WIDTH-1]) ? (WIDTH'(0) - bus.req_msg_a)
                                                           : bus.req_msg_a;
        w_b_mag = (w_use_signed && bus.req_msg_b[WIDTH-1]) ? (WIDTH'(0) - bus.req_msg_b)
                                                           : bus.req_msg_b;
    end

    // Partial product of the shifted multiplicand and the low multiplier digit.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_b_sh[i]) begin
                w_pp = w_pp + (r_a_sh << i);
            end
        end
        w_sum    = r_acc + w_pp;
        w_b_next = r_b_sh >> BITS_PER_CYCLE;
        w_last   = (r_cnt == c_CNT_W'(1)) || ((EARLY_EXIT != 0) && (w_b_next == '0));
        w_result = r_neg ? (-w_sum) : w_sum;
    end

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_resp_val <= 1'b0;
            r_resp_msg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_val) begin
                        r_a_sh  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b_sh  <= w_b_mag;
                        r_neg   <= w_use_signed && (bus.req_msg_a[WIDTH-1] ^ bus.req_msg_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_cnt   <= c_CNT_W'(c_ITER);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc  <= w_sum;
                    r_a_sh <= r_a_sh << BITS_PER_CYCLE;
                    r_b_sh <= w_b_next;
                    r_cnt  <= r_cnt - c_CNT_W'(1);
                    if (w_last) begin
                        r_resp_msg <= w_result;
                        r_resp_val <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.resp_rdy) begin
                        r_resp_val <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_rdy  = (r_state == S_IDLE);
    assign bus.resp_val = r_resp_val;
    assign bus.resp_msg = r_resp_msg;

endmodule
`default_nettype wire

// File: tb/tb_iter_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_multiplier
// Description : Self-checking bench for iter_multiplier. Two instances share
//               request stimulus: u_dut0 (radix 2, signed, early exit) and
//               u_dut1 (radix 16, unsigned only, fixed latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_multiplier;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    iter_multiplier_if #(.WIDTH(32)) bus0 ();
    iter_multiplier_if #(.WIDTH(32)) bus1 ();

    iter_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1), .SIGNED_EN(1), .EARLY_EXIT(1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    iter_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(4), .SIGNED_EN(0), .EARLY_EXIT(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input bit signed_mode);
        longint sp;
        if (signed_mode) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Early-exit latency at radix 2: bit length of |b|, at least one cycle.
    function automatic int model_lat_early(input logic [31:0] b, input bit signed_mode);
        logic [31:0] mag;
        int          len;
        mag = (signed_mode && b[31]) ? (32'd0 - b) : b;
        len = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
        return (len == 0) ? 1 : len;
    endfunction

    task automatic drive(input bit en0, input bit en1, input logic val,
                         input logic [31:0] a, input logic [31:0] b, input logic s);
        if (en0) begin
            bus0.req_val = val; bus0.req_msg_a = a; bus0.req_msg_b = b; bus0.req_signed = s;
        end
        if (en1) begin
            bus1.req_val = val; bus1.req_msg_a = a; bus1.req_msg_b = b; bus1.req_signed = s;
        end
    endtask

    // Waits (bounded) for u_dut0's response after an accept edge; k=0 on timeout.
    task automatic wait_resp0(output int k, output logic [63:0] m);
        k = 0;
        m = '0;
        for (int c = 1; c <= 80 && k == 0; c++) begin
            @(posedge clk); #1;
            if (bus0.resp_val) begin
                k = c;
                m = bus0.resp_msg;
            end
        end
    endtask

    // One transaction on both instances, operands scrambled while busy.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic s);
        int          k0, k1;
        logic [63:0] m0, m1;
        k0 = 0; k1 = 0; m0 = '0; m1 = '0;
        bus0.resp_rdy = 1'b1;
        bus1.resp_rdy = 1'b1;
        drive(1, 1, 1'b1, a, b, s);
        @(posedge clk); #1;
        check("accept0", {63'd0, bus0.req_rdy}, 64'd0);
        check("accept1", {63'd0, bus1.req_rdy}, 64'd0);
        for (int c = 1; c <= 80 && (k0 == 0 || k1 == 0); c++) begin
            drive(1, 1, 1'b0, $urandom, $urandom, 1'($urandom));
            @(posedge clk); #1;
            if (k0 == 0 && bus0.resp_val) begin k0 = c; m0 = bus0.resp_msg; end
            if (k1 == 0 && bus1.resp_val) begin k1 = c; m1 = bus1.resp_msg; end
        end
        check("lat0",  64'(k0), 64'(model_lat_early(b, s)));
        check("prod0", m0, model_prod(a, b, s));
        check("lat1",  64'(k1), 64'd8);
        check("prod1", m1, model_prod(a, b, 1'b0));
        @(posedge clk); #1;
        check("idle0", {63'd0, bus0.req_rdy}, 64'd1);
        check("idle1", {63'd0, bus1.req_rdy}, 64'd1);
        check("hold0", bus0.resp_msg, model_prod(a, b, s));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k, stale;
        logic [63:0] m;
        logic [31:0] ra, rb;

        // Reset held with a pending request.
        rst = 1'b1;
        bus0.resp_rdy = 1'b0;
        bus1.resp_rdy = 1'b0;
        drive(1, 1, 1'b1, 32'd5, 32'd5, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_val0", {63'd0, bus0.resp_val}, 64'd0);
        check("rst_msg0", bus0.resp_msg, 64'd0);
        check("rst_rdy0", {63'd0, bus0.req_rdy}, 64'd1);
        check("rst_val1", {63'd0, bus1.resp_val}, 64'd0);
        drive(1, 1, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("rst_noacc", {63'd0, bus0.req_rdy}, 64'd1);

        // Directed products.
        run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_txn(32'd100,      32'd100,      1'b0);
        run_txn(32'd65536,    32'd0,        1'b0);
        run_txn(32'hFFFFFFFD, 32'd7,        1'b1);
        run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        run_txn(32'h80000000, 32'h80000000, 1'b1);
        run_txn(32'd7,        32'hFFFFFFF6, 1'b1);
        run_txn(32'h80000000, 32'h00000001, 1'b1);

        // Randomized products with varied multiplier bit lengths.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = 32'd0 - rb;
            run_txn(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Backpressure on u_dut0 with a competing request pending.
        bus0.resp_rdy = 1'b0;
        drive(1, 0, 1'b1, 32'd100, 32'd100, 1'b0);
        @(posedge clk); #1;
        drive(1, 0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_resp0(k, m);
        check("bp_lat", 64'(k), 64'd7);
        check("bp_msg", m, 64'h2710);
        drive(1, 0, 1'b1, 32'd12, 32'd30, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_val", {63'd0, bus0.resp_val}, 64'd1);
            check("bp_hold_msg", bus0.resp_msg, 64'h2710);
            check("bp_hold_rdy", {63'd0, bus0.req_rdy}, 64'd0);
        end
        bus0.resp_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_val", {63'd0, bus0.resp_val}, 64'd0);
        check("bp_rel_rdy", {63'd0, bus0.req_rdy}, 64'd1);
        check("bp_rel_msg", bus0.resp_msg, 64'h2710);
        @(posedge clk); #1;
        check("bp_next_acc", {63'd0, bus0.req_rdy}, 64'd0);
        drive(1, 0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_resp0(k, m);
        check("bp_next_lat", 64'(k), 64'd5);
        check("bp_next_msg", m, 64'h168);
        @(posedge clk); #1;

        // Asynchronous reset while a result is held in DONE.
        bus0.resp_rdy = 1'b0;
        drive(1, 0, 1'b1, 32'd7, 32'd9, 1'b0);
        @(posedge clk); #1;
        drive(1, 0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_resp0(k, m);
        check("ar_msg", m, 64'd63);
        #2 rst = 1'b1;
        #1;
        check("ar_val", {63'd0, bus0.resp_val}, 64'd0);
        check("ar_clr", bus0.resp_msg, 64'd0);
        check("ar_rdy", {63'd0, bus0.req_rdy}, 64'd1);
        @(negedge clk) rst = 1'b0;
        bus0.resp_rdy = 1'b1;

        // Reset in the middle of a full-length operation.
        drive(1, 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        @(posedge clk); #1;
        drive(1, 0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mc_val", {63'd0, bus0.resp_val}, 64'd0);
        @(negedge clk) rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus0.resp_val) stale++;
        end
        check("mc_stale", 64'(stale), 64'd0);
        check("mc_rdy", {63'd0, bus0.req_rdy}, 64'd1);
        run_txn(32'd12, 32'd30, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
